// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared encodings and types for the alu_reg datapath sequencer
package dp_pkg;

  typedef enum logic [1:0] {
    OP_ALU_REG = 2'b00,
    OP_ALU_IMM = 2'b01,
    OP_LOAD    = 2'b10,
    OP_NOP     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SHL   = 5'b10000;
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef struct packed {
    op_e         op;
    logic [4:0]  fs;
    logic        c0;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [63:0] imm;
    logic        setf;
    logic [63:0] data;
  } cmd_t;

  typedef struct packed {
    logic [4:0]  fs;
    logic        c0;
    logic [4:0]  addra;
    logic [4:0]  addrb;
    logic [4:0]  addrr;
    logic [63:0] k;
    logic        s;
    logic        w;
    logic        sel_ld;
    logic [63:0] ld_data;
    logic        done;
  } ctl_t;

endpackage

// File: rtl/dp_sequencer.sv
// rtl/dp_sequencer.sv - command-driven micro-sequencer owning the alu_reg control word
module dp_sequencer
  import dp_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_fs,
  input  logic        cmd_c0,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rn,
  input  logic [4:0]  cmd_rm,
  input  logic [63:0] cmd_imm,
  input  logic        cmd_setf,
  input  logic [63:0] cmd_data,
  output logic [4:0]  fs,
  output logic        c0,
  output logic [4:0]  addrA,
  output logic [4:0]  addrB,
  output logic [4:0]  addrR,
  output logic [63:0] k,
  output logic        s,
  output logic        w,
  output logic        sel_ld,
  output logic [63:0] ld_data,
  input  logic [3:0]  status,
  output logic [3:0]  flags,
  output logic        done,
  output logic        busy
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q;
  cmd_t       cmd_in, hold_q, hold_d;
  ctl_t       ctl_q, ctl_d;
  logic [3:0] flags_q;
  logic       accept;

  assign accept = cmd_valid && (state_q == ST_IDLE);

  always_comb begin
    cmd_in      = '0;
    cmd_in.op   = op_e'(cmd_op);
    cmd_in.fs   = cmd_fs;
    cmd_in.c0   = cmd_c0;
    cmd_in.rd   = cmd_rd;
    cmd_in.rn   = cmd_rn;
    cmd_in.rm   = cmd_rm;
    cmd_in.imm  = cmd_imm;
    cmd_in.setf = cmd_setf;
    cmd_in.data = cmd_data;
  end

  assign hold_d = accept ? cmd_in : hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_in.op)
            OP_ALU_REG, OP_ALU_IMM: state_d = ST_EXEC;
            OP_LOAD:                state_d = ST_WB;
            default:                state_d = ST_DONE;
          endcase
        end
      end
      ST_EXEC: if (cnt_q == 4'd0) state_d = ST_WB;
      ST_WB:   state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control word is computed from the next state so every output leaves a flop.
  always_comb begin
    ctl_d = '0;
    if ((state_d == ST_EXEC) || (state_d == ST_WB)) begin
      if (hold_d.op == OP_LOAD) begin
        ctl_d.sel_ld  = 1'b1;
        ctl_d.ld_data = hold_d.data;
      end else begin
        ctl_d.fs    = hold_d.fs;
        ctl_d.c0    = hold_d.c0;
        ctl_d.addra = hold_d.rn;
        ctl_d.addrb = hold_d.rm;
        ctl_d.s     = (hold_d.op == OP_ALU_IMM);
        ctl_d.k     = (hold_d.op == OP_ALU_IMM) ? hold_d.imm : 64'd0;
      end
    end
    if (state_d == ST_WB) begin
      ctl_d.addrr = hold_d.rd;
      ctl_d.w     = !(ZERO_REG_EN && (hold_d.rd == ZERO_REG));
    end
    if (state_d == ST_DONE) begin
      ctl_d.done = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      ctl_q   <= '0;
      cnt_q   <= 4'd0;
      flags_q <= 4'd0;
    end else begin
      hold_q <= hold_d;
      ctl_q  <= ctl_d;
      if (accept) begin
        cnt_q <= 4'(EXEC_CYCLES - 1);
      end else if ((state_q == ST_EXEC) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Status is sampled while the write-back control word is on the datapath.
      if ((state_q == ST_WB) && hold_q.setf && (hold_q.op != OP_LOAD)) begin
        flags_q <= status;
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign fs        = ctl_q.fs;
  assign c0        = ctl_q.c0;
  assign addrA     = ctl_q.addra;
  assign addrB     = ctl_q.addrb;
  assign addrR     = ctl_q.addrr;
  assign k         = ctl_q.k;
  assign s         = ctl_q.s;
  assign w         = ctl_q.w;
  assign sel_ld    = ctl_q.sel_ld;
  assign ld_data   = ctl_q.ld_data;
  assign done      = ctl_q.done;
  assign flags     = flags_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// tb/tb_dp_sequencer.sv - directed bench: sequencer driving a behavioural register file and ALU
module tb_dp_sequencer;
  import dp_pkg::*;

  logic        clk, rst;
  logic        v0, v1, v2;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_fs, cmd_rd, cmd_rn, cmd_rm;
  logic        cmd_c0, cmd_setf;
  logic [63:0] cmd_imm, cmd_data;

  logic        cmd_ready, c0, s, w, sel_ld, done, busy;
  logic [4:0]  fs, addrA, addrB, addrR;
  logic [63:0] k, ld_data;
  logic [3:0]  flags, status;

  logic        ready_z, c0_z, s_z, w_z, sel_ld_z, done_z, busy_z;
  logic [4:0]  fs_z, addrA_z, addrB_z, addrR_z;
  logic [63:0] k_z, ld_data_z;
  logic [3:0]  flags_z;

  logic        ready_e, c0_e, s_e, w_e, sel_ld_e, done_e, busy_e;
  logic [4:0]  fs_e, addrA_e, addrB_e, addrR_e;
  logic [63:0] k_e, ld_data_e;
  logic [3:0]  flags_e;

  int checks = 0;
  int failures = 0;

  dp_sequencer #(.EXEC_CYCLES(1), .ZERO_REG_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(v0), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_fs(cmd_fs), .cmd_c0(cmd_c0), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .cmd_setf(cmd_setf), .cmd_data(cmd_data), .fs(fs), .c0(c0),
    .addrA(addrA), .addrB(addrB), .addrR(addrR), .k(k), .s(s), .w(w), .sel_ld(sel_ld),
    .ld_data(ld_data), .status(status), .flags(flags), .done(done), .busy(busy)
  );

  dp_sequencer #(.EXEC_CYCLES(1), .ZERO_REG_EN(1'b0)) dut_z0 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(ready_z), .cmd_op(cmd_op),
    .cmd_fs(cmd_fs), .cmd_c0(cmd_c0), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .cmd_setf(cmd_setf), .cmd_data(cmd_data), .fs(fs_z), .c0(c0_z),
    .addrA(addrA_z), .addrB(addrB_z), .addrR(addrR_z), .k(k_z), .s(s_z), .w(w_z),
    .sel_ld(sel_ld_z), .ld_data(ld_data_z), .status(4'd0), .flags(flags_z),
    .done(done_z), .busy(busy_z)
  );

  dp_sequencer #(.EXEC_CYCLES(3), .ZERO_REG_EN(1'b1)) dut_e3 (
    .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(ready_e), .cmd_op(cmd_op),
    .cmd_fs(cmd_fs), .cmd_c0(cmd_c0), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .cmd_setf(cmd_setf), .cmd_data(cmd_data), .fs(fs_e), .c0(c0_e),
    .addrA(addrA_e), .addrB(addrB_e), .addrR(addrR_e), .k(k_e), .s(s_e), .w(w_e),
    .sel_ld(sel_ld_e), .ld_data(ld_data_e), .status(4'd0), .flags(flags_e),
    .done(done_e), .busy(busy_e)
  );

  // Behavioural alu_reg: 32x64 register file, ALU, and the din mux.
  logic [63:0] rf [32] = '{default: 64'd0};
  logic [63:0] opa, opb, alu_f, din;
  logic        alu_c;

  always_comb begin
    opa   = rf[addrA];
    opb   = s ? k : rf[addrB];
    alu_c = 1'b0;
    alu_f = 64'd0;
    case (fs)
      FS_AND:  alu_f = opa & opb;
      FS_ADD:  {alu_c, alu_f} = {1'b0, opa} + {1'b0, opb} + {64'd0, c0};
      FS_SHL:  alu_f = opa << opb[5:0];
      default: alu_f = 64'd0;
    endcase
    status = {1'b0, alu_c, alu_f[63], (alu_f == 64'd0)};
    din    = sel_ld ? ld_data : alu_f;
  end

  always @(posedge clk) begin
    if (w) rf[addrR] <= din;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] tgt, input logic [1:0] op, input logic [4:0] f,
                      input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                      input logic [63:0] imm, input logic setf, input logic [63:0] data);
    cmd_op = op; cmd_fs = f; cmd_c0 = 1'b0; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
    cmd_imm = imm; cmd_setf = setf; cmd_data = data;
    {v2, v1, v0} = tgt;
    tick();
    {v2, v1, v0} = 3'b000;
  endtask

  logic [4:0]  ld_rd  [4] = '{5'd20, 5'd21, 5'd22, 5'd23};
  logic [63:0] ld_val [4] = '{64'd18, 64'd7, 64'd12, 64'd5};

  initial begin
    rst = 1'b1; {v2, v1, v0} = 3'b000;
    cmd_op = 2'b00; cmd_fs = 5'd0; cmd_c0 = 1'b0; cmd_rd = 5'd0; cmd_rn = 5'd0;
    cmd_rm = 5'd0; cmd_imm = 64'd0; cmd_setf = 1'b0; cmd_data = 64'd0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_w", 64'(w), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready_e", 64'(ready_e), 64'd1);

    for (int i = 0; i < 4; i++) begin
      chk("ld_ready", 64'(cmd_ready), 64'd1);
      send(3'b001, OP_LOAD, 5'd0, ld_rd[i], 5'd0, 5'd0, 64'd0, 1'b0, ld_val[i]);
      chk("ld_w", 64'(w), 64'd1);
      chk("ld_sel", 64'(sel_ld), 64'd1);
      chk("ld_addrR", 64'(addrR), 64'(ld_rd[i]));
      chk("ld_data", ld_data, ld_val[i]);
      chk("ld_addrA", 64'(addrA), 64'd0);
      tick();
      chk("ld_done", 64'(done), 64'd1);
      chk("ld_w_off", 64'(w), 64'd0);
      tick();
      chk("ld_idle", 64'(cmd_ready), 64'd1);
    end
    chk("r20", rf[20], 64'd18);
    chk("r21", rf[21], 64'd7);
    chk("r22", rf[22], 64'd12);
    chk("r23", rf[23], 64'd5);

    send(3'b001, OP_ALU_REG, FS_ADD, 5'd3, 5'd22, 5'd23, 64'd0, 1'b0, 64'd0);
    chk("add_addrA", 64'(addrA), 64'd22);
    chk("add_addrB", 64'(addrB), 64'd23);
    chk("add_s", 64'(s), 64'd0);
    chk("add_k", k, 64'd0);
    chk("add_fs", 64'(fs), 64'(FS_ADD));
    chk("add_w_exec", 64'(w), 64'd0);
    tick();
    chk("add_w_wb", 64'(w), 64'd1);
    chk("add_addrR", 64'(addrR), 64'd3);
    chk("add_addrA_wb", 64'(addrA), 64'd22);
    chk("add_sel", 64'(sel_ld), 64'd0);
    tick();
    chk("add_done", 64'(done), 64'd1);
    chk("r3", rf[3], 64'd17);
    tick();

    send(3'b001, OP_ALU_IMM, FS_SHL, 5'd1, 5'd21, 5'd0, 64'd3, 1'b0, 64'd0);
    chk("imm_s", 64'(s), 64'd1);
    chk("imm_k", k, 64'd3);
    chk("imm_w_exec", 64'(w), 64'd0);
    tick();
    chk("imm_s_wb", 64'(s), 64'd1);
    chk("imm_k_wb", k, 64'd3);
    chk("imm_w_wb", 64'(w), 64'd1);
    tick();
    chk("r1", rf[1], 64'd56);
    tick();

    send(3'b001, OP_ALU_REG, FS_AND, 5'd5, 5'd20, 5'd22, 64'd0, 1'b1, 64'd0);
    chk("and_flags_exec", 64'(flags), 64'd0);
    tick();
    chk("and_w", 64'(w), 64'd1);
    chk("and_flags_wb", 64'(flags), 64'd0);
    tick();
    chk("and_flags", 64'(flags), 64'h1);
    chk("r5", rf[5], 64'd0);
    tick();

    send(3'b011, OP_LOAD, 5'd0, 5'd31, 5'd0, 5'd0, 64'd0, 1'b0, 64'd99);
    chk("r31_w_zero_en", 64'(w), 64'd0);
    chk("r31_w_z0", 64'(w_z), 64'd1);
    chk("r31_addrR_z0", 64'(addrR_z), 64'd31);
    tick();
    chk("r31_done", 64'(done), 64'd1);
    chk("r31_done_z0", 64'(done_z), 64'd1);
    chk("r31_w_done", 64'(w), 64'd0);
    chk("r31_rf", rf[31], 64'd0);
    chk("flags_hold", 64'(flags), 64'h1);
    tick();

    cmd_op = OP_ALU_REG; cmd_fs = FS_ADD; cmd_rd = 5'd4; cmd_rn = 5'd1; cmd_rm = 5'd2;
    cmd_setf = 1'b0; v2 = 1'b1;
    chk("b2b_ready0", 64'(ready_e), 64'd1);
    tick();
    cmd_op = OP_LOAD; cmd_rd = 5'd7; cmd_data = 64'h55;
    chk("b2b_ready1", 64'(ready_e), 64'd0);
    chk("b2b_busy1", 64'(busy_e), 64'd1);
    chk("b2b_addrA1", 64'(addrA_e), 64'd1);
    chk("b2b_w1", 64'(w_e), 64'd0);
    tick();
    chk("b2b_w2", 64'(w_e), 64'd0);
    chk("b2b_addrB2", 64'(addrB_e), 64'd2);
    tick();
    chk("b2b_w3", 64'(w_e), 64'd0);
    tick();
    chk("b2b_w4", 64'(w_e), 64'd1);
    chk("b2b_addrR4", 64'(addrR_e), 64'd4);
    chk("b2b_sel4", 64'(sel_ld_e), 64'd0);
    tick();
    chk("b2b_done5", 64'(done_e), 64'd1);
    chk("b2b_ready5", 64'(ready_e), 64'd0);
    tick();
    chk("b2b_ready6", 64'(ready_e), 64'd1);
    chk("b2b_done6", 64'(done_e), 64'd0);
    tick();
    v2 = 1'b0;
    chk("b2b_w7", 64'(w_e), 64'd1);
    chk("b2b_sel7", 64'(sel_ld_e), 64'd1);
    chk("b2b_addrR7", 64'(addrR_e), 64'd7);
    chk("b2b_ld7", ld_data_e, 64'h55);
    tick();
    chk("b2b_done8", 64'(done_e), 64'd1);
    tick();

    send(3'b001, OP_ALU_REG, FS_ADD, 5'd6, 5'd20, 5'd21, 64'd0, 1'b1, 64'd0);
    chk("rst_exec_busy", 64'(busy), 64'd1);
    chk("rst_exec_w", 64'(w), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_w", 64'(w), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    tick();
    chk("abort_r6", rf[6], 64'd0);
    chk("abort_w2", 64'(w), 64'd0);

    send(3'b001, OP_NOP, 5'd0, 5'd9, 5'd0, 5'd0, 64'd0, 1'b0, 64'd0);
    chk("nop_done", 64'(done), 64'd1);
    chk("nop_w", 64'(w), 64'd0);
    chk("nop_busy", 64'(busy), 64'd1);
    tick();
    chk("nop_ready", 64'(cmd_ready), 64'd1);
    chk("nop_done_off", 64'(done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
